mem_access_ctrl: RTL and testbench

// - Consumer of the EX/MEM pipeline latch outputs: issues the MEM-stage data request to the dcache.
// - Generates memStall; the hazard unit uses it to hold EX/MEM (exW=0).
// - Registers the MEM/WB result for the writeback stage and latches the processor halt.

---
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage controller. Takes the EX/MEM latch outputs, issues the data
//   request to the dcache, stalls the pipeline on a miss, registers the
//   MEM/WB result for writeback and latches the processor halt.
//
//   Optional feature macro: MEM_TIMEOUT_EN. When defined, a request that waits
//   TIMEOUT_CYC-1 stalled cycles without dhit is aborted and memTimeout is set.
//   When undefined, a request waits indefinitely and memTimeout is tied 0.
//
// Handshake: a request (memcuDRE/memcuDWE) is held by the EX/MEM latch until
//   the cache answers with dhit. A cycle with req & dhit completes the access
//   with no stall; req & ~dhit stalls (memStall=1) and the request stays up.
//
// Ports
//   CLK, RST          clock (rising edge), async active-high reset
//   memcuDRE/DWE      load / store request from EX/MEM
//   memcuHALT         halt instruction in MEM
//   memMemToReg       writeback select: 1 = load data
//   memWEN, memwsel   register-file write enable / destination
//   memOutput_Port    ALU result / byte address
//   memrdat2          store data
//   meminstr          instruction word (LUI immediate)
//   memLUIflag        LUI: write {meminstr[15:0],16'h0}
//   dhit, dmemload    dcache completion and load data
//   dmemREN/WEN       dcache read / write request
//   dmemaddr/store    dcache address / store data
//   memStall          MEM stage holding, upstream latches freeze
//   wbWEN/wsel/wdat   registered MEM/WB result
//   halt              sticky halt
//   memTimeout        sticky access-abort flag
//   state_dbg         FSM state (0 IDLE, 1 WAIT, 2 HALTED)
// ----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memcuDRE,
  input  logic        memcuDWE,
  input  logic        memcuHALT,
  input  logic        memMemToReg,
  input  logic        memWEN,
  input  logic [4:0]  memwsel,
  input  logic [31:0] memOutput_Port,
  input  logic [31:0] memrdat2,
  input  logic [31:0] meminstr,
  input  logic        memLUIflag,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        memStall,
  output logic        wbWEN,
  output logic [4:0]  wbwsel,
  output logic [31:0] wbwdat,
  output logic        halt,
  output logic        memTimeout,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        req;
  logic        halted;
  logic        timeout_hit;
  logic        halt_go;
  logic [31:0] wb_data_nxt;

  assign req       = memcuDRE | memcuDWE;
  assign halted    = (state == HALTED);
  assign dmemaddr  = memOutput_Port;
  assign dmemstore = memrdat2;
  assign state_dbg = state;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // The counter advances on every stalled cycle of a request, including the
  // IDLE cycle in which the miss is first seen, so cnt equals the number of
  // stalled cycles already spent. Any non-stalled cycle (dhit, abort, no req)
  // clears it.
  assign timeout_hit = (state == WAIT) & req & ~dhit &
                       (wait_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt   <= 8'd0;
      memTimeout <= 1'b0;
    end else begin
      if (memStall) wait_cnt <= wait_cnt + 8'd1;
      else          wait_cnt <= 8'd0;
      if (timeout_hit) memTimeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit = 1'b0;
  assign memTimeout  = 1'b0;
`endif

  // Cache requests and stall. Reset forces them low so an outstanding miss
  // is dropped the instant RST rises. On store+load, the store wins.
  always_comb begin
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    memStall = 1'b0;
    if (!RST && !halted && !timeout_hit) begin
      dmemWEN  = memcuDWE;
      dmemREN  = memcuDRE & ~memcuDWE;
      memStall = req & ~dhit;
    end
  end

  assign halt_go = memcuHALT & ~memStall & ~halted;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (halt_go) state_nxt = HALTED;
               else if (memStall) state_nxt = WAIT;
      WAIT:    if (halt_go) state_nxt = HALTED;
               else if (!memStall) state_nxt = IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    wb_data_nxt = memOutput_Port;
    if (memLUIflag)       wb_data_nxt = {meminstr[15:0], 16'h0000};
    else if (memMemToReg) wb_data_nxt = dmemload;
  end

  // MEM/WB register. Stall, abort and halted cycles insert a bubble and keep
  // the previous destination/data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wbWEN  <= 1'b0;
      wbwsel <= 5'd0;
      wbwdat <= 32'd0;
      halt   <= 1'b0;
    end else begin
      if (halted || memStall || timeout_hit) begin
        wbWEN <= 1'b0;
      end else begin
        wbWEN  <= memWEN;
        wbwsel <= memwsel;
        wbwdat <= wb_data_nxt;
      end
      if (halt_go) halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        CLK;
  logic        RST;
  logic        memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN, memLUIflag, dhit;
  logic [4:0]  memwsel;
  logic [31:0] memOutput_Port, memrdat2, meminstr, dmemload;
  logic        dmemREN, dmemWEN, memStall, wbWEN, halt, memTimeout;
  logic [31:0] dmemaddr, dmemstore, wbwdat;
  logic [4:0]  wbwsel;
  logic [1:0]  state_dbg;

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];

  mem_access_ctrl #(.TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST(RST),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
    .memMemToReg(memMemToReg), .memWEN(memWEN), .memwsel(memwsel),
    .memOutput_Port(memOutput_Port), .memrdat2(memrdat2), .meminstr(meminstr),
    .memLUIflag(memLUIflag), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .memStall(memStall), .wbWEN(wbWEN), .wbwsel(wbwsel), .wbwdat(wbwdat),
    .halt(halt), .memTimeout(memTimeout), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    memcuDRE = 0; memcuDWE = 0; memcuHALT = 0; memMemToReg = 0; memWEN = 0;
    memLUIflag = 0; dhit = 0; memwsel = 5'd0; memOutput_Port = 32'd0;
    memrdat2 = 32'd0; meminstr = 32'd0; dmemload = 32'd0;
  endtask

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic push_exp(input logic [4:0] sel, input logic [31:0] dat);
    exp_q.push_back({sel, dat});
  endtask

  // monitor: every writeback presented by the DUT must match the queue head
  always @(negedge CLK) begin
    if (wbWEN === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got wsel=%0d wdat=0x%08h expected no write", wbwsel, wbwdat);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wbwsel, wbwdat} !== e) begin
          fails++;
          $display("FAIL wb_data: got wsel=%0d wdat=0x%08h expected wsel=%0d wdat=0x%08h",
                   wbwsel, wbwdat, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    drive_idle();
    RST = 1'b1;
    memcuDRE = 1; memcuDWE = 1;
    next_cycle(); next_cycle(); #1;
    check("rst_dmemREN", {31'd0, dmemREN}, 0);
    check("rst_dmemWEN", {31'd0, dmemWEN}, 0);
    check("rst_memStall", {31'd0, memStall}, 0);
    check("rst_wbWEN", {31'd0, wbWEN}, 0);
    check("rst_wbwsel", {27'd0, wbwsel}, 0);
    check("rst_wbwdat", wbwdat, 0);
    check("rst_halt", {31'd0, halt}, 0);
    check("rst_timeout", {31'd0, memTimeout}, 0);
    check("rst_state", {30'd0, state_dbg}, 0);

    next_cycle(); RST = 1'b0; drive_idle();

    // zero-wait load
    next_cycle();
    memcuDRE = 1; memOutput_Port = 32'h100; memMemToReg = 1; memWEN = 1;
    memwsel = 5'd5; dhit = 1; dmemload = 32'hDEADBEEF; #1;
    check("zw_stall", {31'd0, memStall}, 0);
    check("zw_ren", {31'd0, dmemREN}, 1);
    check("zw_wen", {31'd0, dmemWEN}, 0);
    check("zw_addr", dmemaddr, 32'h100);
    push_exp(5'd5, 32'hDEADBEEF);

    // store, miss for 3 cycles, no register write
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive_idle();
      memcuDWE = 1; memOutput_Port = 32'h200; memrdat2 = 32'h1234;
      memwsel = 5'd7; dhit = (i == 3); #1;
      check("st_wen", {31'd0, dmemWEN}, 1);
      check("st_ren", {31'd0, dmemREN}, 0);
      check("st_stall", {31'd0, memStall}, (i < 3) ? 1 : 0);
      check("st_data", dmemstore, 32'h1234);
      check("st_state", {30'd0, state_dbg}, (i == 0) ? 0 : 1);
    end

    // load+store together: store wins; ALU result written back
    next_cycle(); drive_idle();
    memcuDRE = 1; memcuDWE = 1; dhit = 1; memOutput_Port = 32'h55;
    memWEN = 1; memwsel = 5'd3; #1;
    check("both_ren", {31'd0, dmemREN}, 0);
    check("both_wen", {31'd0, dmemWEN}, 1);
    push_exp(5'd3, 32'h55);

    // LUI, no request
    next_cycle(); drive_idle();
    memLUIflag = 1; meminstr = 32'h1234ABCD; memWEN = 1; memwsel = 5'd9;
    memOutput_Port = 32'h777; #1;
    check("lui_ren", {31'd0, dmemREN}, 0);
    check("lui_wen", {31'd0, dmemWEN}, 0);
    check("lui_stall", {31'd0, memStall}, 0);
    push_exp(5'd9, 32'hABCD0000);

    // ALU passthrough
    next_cycle(); drive_idle();
    memWEN = 1; memwsel = 5'd31; memOutput_Port = 32'hCAFEF00D; #1;
    push_exp(5'd31, 32'hCAFEF00D);

    // load miss 2 cycles, data captured on the dhit cycle
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive_idle();
      memcuDRE = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd12; memOutput_Port = 32'h40;
      dhit = (i == 2); dmemload = (i == 2) ? 32'h89ABCDEF : 32'h11111111; #1;
      check("ldm_stall", {31'd0, memStall}, (i < 2) ? 1 : 0);
    end
    push_exp(5'd12, 32'h89ABCDEF);

    // dhit without a request is ignored
    next_cycle(); drive_idle();
    dhit = 1; #1;
    check("nohit_stall", {31'd0, memStall}, 0);
    check("nohit_state", {30'd0, state_dbg}, 0);

    // reset in the middle of a miss
    next_cycle(); drive_idle();
    memcuDRE = 1; memWEN = 1; memwsel = 5'd2; #1;
    check("rw_stall0", {31'd0, memStall}, 1);
    next_cycle(); #1;
    check("rw_state1", {30'd0, state_dbg}, 1);
    RST = 1'b1; #1;
    check("rw_ren", {31'd0, dmemREN}, 0);
    check("rw_stall", {31'd0, memStall}, 0);
    check("rw_wbwdat", wbwdat, 0);
    check("rw_wbwsel", {27'd0, wbwsel}, 0);
    check("rw_halt", {31'd0, halt}, 0);
    next_cycle(); RST = 1'b0; drive_idle(); #1;
    check("rw_state", {30'd0, state_dbg}, 0);

    // long miss: aborts at cycle 15 with the timeout, otherwise keeps waiting
    for (int i = 0; i < 16; i++) begin
      next_cycle(); drive_idle();
      memcuDRE = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd20; #1;
      check("to_stall", {31'd0, memStall}, (i < 15 || !TO_EN) ? 1 : 0);
      check("to_ren", {31'd0, dmemREN}, (i < 15 || !TO_EN) ? 1 : 0);
      check("to_flag", {31'd0, memTimeout}, 0);
    end
`ifdef MEM_TIMEOUT_EN
    next_cycle(); drive_idle(); #1;
    check("to_flag_set", {31'd0, memTimeout}, 1);
    check("to_state", {30'd0, state_dbg}, 0);
`else
    next_cycle();
    dhit = 1; dmemload = 32'h600DCAFE; #1;
    check("to_stall_end", {31'd0, memStall}, 0);
    check("to_flag_off", {31'd0, memTimeout}, 0);
    push_exp(5'd20, 32'h600DCAFE);
`endif

    // halt behind a 2-cycle miss
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive_idle();
      memcuDRE = 1; memcuHALT = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd4;
      dhit = (i == 2); dmemload = 32'h0BADF00D; #1;
      check("hm_halt", {31'd0, halt}, 0);
      check("hm_stall", {31'd0, memStall}, (i < 2) ? 1 : 0);
    end
    push_exp(5'd4, 32'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); dhit = 0; #1;
      check("hd_halt", {31'd0, halt}, 1);
      check("hd_ren", {31'd0, dmemREN}, 0);
      check("hd_stall", {31'd0, memStall}, 0);
      check("hd_state", {30'd0, state_dbg}, 2);
    end

    next_cycle(); drive_idle();
    next_cycle(); next_cycle(); #2;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard bound on total run time
  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected finish before 20000");
    $fatal(1, "bench time limit");
  end

endmodule
